// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage core.
// Tracks in-flight destinations of EX/MEM/WB and derives forwards, load-use stalls and redirect flushes.
module hazard_ctrl #(
   parameter int         CNT_W     = 32,
   parameter logic [1:0] LOAD_WSEL = 2'b11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [4:0]       id_rd,
   input  logic             id_rf_we,
   input  logic [1:0]       id_rf_wsel,
   input  logic             ex_redirect,
   input  logic             hold,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             stall_pc,
   output logic             stall_ifid,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       we;
      logic       ld;
   } entry_t;

   entry_t ex_q, mem_q, wb_q;
   entry_t ex_d;
   logic   advance;
   logic   inc_stall, inc_flush;
   logic   use_a, use_b;
   logic   ex_a, ex_b, lu_a, lu_b, lu;

   function automatic logic writes(input entry_t e, input logic [4:0] r);
      return e.v & e.we & (e.rd == r) & (r != 5'd0);
   endfunction

   // A load in EX cannot forward yet; its operand is reported as RF and the stall covers it.
   function automatic logic [1:0] pick_src(input logic used, input logic lu_op, input logic [4:0] r);
      logic [1:0] src;
      src = 2'b00;
      if (used && !lu_op) begin
         if (writes(ex_q, r))
            src = 2'b01;
         else if (writes(mem_q, r))
            src = 2'b10;
         else if (writes(wb_q, r))
            src = 2'b11;
      end
      return src;
   endfunction

   always_comb begin
      use_a = id_valid & id_rs1_used;
      use_b = id_valid & id_rs2_used;
      ex_a  = use_a & writes(ex_q, id_rs1);
      ex_b  = use_b & writes(ex_q, id_rs2);
      lu_a  = ex_a & ex_q.ld;
      lu_b  = ex_b & ex_q.ld;
      lu    = lu_a | lu_b;
      fwd_a = pick_src(use_a, lu_a, id_rs1);
      fwd_b = pick_src(use_b, lu_b, id_rs2);
   end

   // Control priority is hold, then redirect, then load-use; the bubble replaces the ID entry.
   always_comb begin
      stall_pc   = 1'b0;
      stall_ifid = 1'b0;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      advance    = 1'b1;
      inc_stall  = 1'b0;
      inc_flush  = 1'b0;
      ex_d.v     = id_valid;
      ex_d.rd    = id_rd;
      ex_d.we    = id_rf_we;
      ex_d.ld    = (id_rf_wsel == LOAD_WSEL);
      if (hold) begin
         stall_pc   = 1'b1;
         stall_ifid = 1'b1;
         advance    = 1'b0;
      end else if (ex_redirect) begin
         flush_ifid = 1'b1;
         flush_idex = 1'b1;
         inc_flush  = 1'b1;
         ex_d       = '0;
      end else if (lu) begin
         stall_pc   = 1'b1;
         stall_ifid = 1'b1;
         flush_idex = 1'b1;
         inc_stall  = 1'b1;
         ex_d       = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q      <= '0;
         mem_q     <= '0;
         wb_q      <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (advance) begin
         ex_q      <= ex_d;
         mem_q     <= ex_q;
         wb_q      <= mem_q;
         stall_cnt <= stall_cnt + CNT_W'(inc_stall);
         flush_cnt <= flush_cnt + CNT_W'(inc_flush);
      end
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard/forwarding controller for the 5-stage pipelined core (IF/ID/EX/MEM/WB) built around the decode stage's register file and write-back select.
- Keeps a shadow copy of the in-flight destination-register information for EX, MEM and WB.
- From that state it drives operand-forward selects, the load-use stall, and branch/jump flushes.
- Also holds two performance counters.

Parameters:
- CNT_W, 32, width of the stall and flush performance counters.
- LOAD_WSEL, 2'b11, rf_wsel encoding that marks a load (write-back data from DRAM read-out).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  5  source register 1 (instr[19:15]).
- id_rs2  in  5  source register 2 (instr[24:20]).
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- id_rd  in  5  destination register (instr[11:7]).
- id_rf_we  in  1  instruction writes the RF.
- id_rf_wsel  in  2  write-back select of the ID instruction.
- ex_redirect  in  1  EX resolved a taken branch/jump this cycle.
- hold  in  1  global freeze (memory wait).
- fwd_a  out  2  rs1 operand source: 00 RF, 01 EX result, 10 MEM result, 11 WB data.
- fwd_b  out  2  same encoding for rs2.
- stall_pc  out  1  keep PC.
- stall_ifid  out  1  keep IF/ID register.
- flush_ifid  out  1  load bubble into IF/ID.
- flush_idex  out  1  load bubble into ID/EX.
- stall_cnt  out  CNT_W  number of load-use stall cycles.
- flush_cnt  out  CNT_W  number of redirect cycles.

Behaviour:
- State: three shadow entries EX, MEM, WB. Each entry is {v, rd, we, ld}. ld = (wsel == LOAD_WSEL).
- An entry is "writing r" when v & we & rd == r & r != 0.
- Reset:
  - All entries v = 0.
  - Both counters 0.
  - Therefore fwd_a/b = 00 and all stall/flush outputs 0 in the cycle after reset.
  - Reset overrides hold and redirect mid-operation.
- Forwarding (combinational from current inputs and shadow state):
  - fwd_a checks id_rs1 only when id_valid & id_rs1_used; otherwise 00.
  - Priority order: EX writing rs1 and not ld gives 01; else MEM writing gives 10; else WB writing gives 11; else 00.
  - fwd_b uses the same rule on rs2.
  - WB forward is required: the RF is not write-through.
- Load-use hazard (lu): id_valid & EX writing a used rs & EX.ld.
  - In this case fwd for that operand is 00 (that value is not used).
- Priority per cycle: rst > hold > ex_redirect > lu > normal.
  - hold:
    - stall_pc = stall_ifid = 1, flushes 0.
    - Shadow regs and counters unchanged.
  - ex_redirect:
    - flush_ifid = flush_idex = 1, stalls 0, lu is ignored.
    - Next state: EX <= bubble, MEM <= EX, WB <= MEM.
    - flush_cnt += 1.
  - lu:
    - stall_pc = stall_ifid = flush_idex = 1, flush_ifid = 0.
    - Next state: EX <= bubble, MEM <= EX, WB <= MEM.
    - stall_cnt += 1.
    - Lasts exactly one cycle: next cycle the load sits in MEM and forwards via 10.
  - normal:
    - All control outputs 0.
    - Next state: EX <= {id_valid, id_rd, id_rf_we, ld(id_rf_wsel)}, MEM <= EX, WB <= MEM.
- A bubble is v = 0, rd = 0, we = 0, ld = 0.
- Counters wrap modulo 2^CNT_W and never saturate.
- rd = x0 never forwards and never stalls.
- When id_valid = 0, no stall is raised, but the shadow still advances.

Test Plan:
- ALU chain: add x5 then add x6,x5,x1 back-to-back -> fwd_a = 01 in the cycle the second add is in ID; no stall.
- Distance 2/3:
  - add x5; nop; use x5 -> fwd_a = 10.
  - add x5; nop; nop; use x5 -> fwd_a = 11.
  - Producers in EX and MEM both write x5 -> fwd_a = 01 (EX wins).
- Load-use: lw x7 then add x8,x7,x7:
  - Cycle 1: stall_pc = stall_ifid = flush_idex = 1, stall_cnt 0->1.
  - Cycle 2: fwd_a = fwd_b = 10, no stall.
- x0 writes: add x0 then use x0 -> fwd 00; lw x0 then use x0 -> no stall.
- Redirect while lu present: ex_redirect = 1 with lw in EX and a dependent instruction in ID:
  - flush_ifid = flush_idex = 1, stall_pc = 0, flush_cnt +1, stall_cnt unchanged.
  - Next cycle EX shadow v = 0.
- Hold/reset:
  - hold = 1 for 3 cycles with a load-use pending -> outputs stall_pc = stall_ifid = 1 and flush_idex = 0 throughout; stall_cnt unchanged.
  - After hold drops -> lu stall occurs once.
  - rst asserted mid-sequence -> fwd 00 and counters 0 the next cycle.
